// File: rtl/pulse_gen_arbiter_pkg.sv
// pulse_gen_arbiter_pkg: shared state encoding and requester limits for the pulse generator arbiter
package pulse_gen_arbiter_pkg;
  localparam int MAX_REQ = 8;
  localparam int IDX_W = $clog2(MAX_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;
endpackage

// File: rtl/pulse_gen_arbiter_if.sv
// pulse_gen_arbiter_if: requester and generator handshake bundle around the arbiter
interface pulse_gen_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic err;
  logic gen_start;
  logic gen_done;
  logic gen_rst;
  modport master(output req, gen_done, input grant, done, err, gen_start, gen_rst);
  modport slave(input req, gen_done, output grant, done, err, gen_start, gen_rst);
endinterface

// File: rtl/pulse_gen_arbiter_rr_select.sv
// pulse_gen_arbiter_rr_select: first set request scanning upward from ptr+1 with wrap
module pulse_gen_arbiter_rr_select
  import pulse_gen_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NUM_REQ]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
        sel[(int'(ptr) + i) % NUM_REQ] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pulse_gen_arbiter.sv
// pulse_gen_arbiter: round-robin sharing of one pulse generator with a handshake watchdog
module pulse_gen_arbiter
  import pulse_gen_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input logic sys_clk,
  input logic rst,
  pulse_gen_arbiter_if.slave bus
);
  localparam int TO_CTR_SIZE = $clog2(TIMEOUT + 1);
  state_t state, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, sel_oh;
  logic err_q, err_d, start_q, start_d, grst_q, grst_d, sel_any;
  logic [IDX_W-1:0] rr_ptr, rr_d, sel_idx;
  logic [TO_CTR_SIZE-1:0] to_ctr, to_d;
  logic expired;
  pulse_gen_arbiter_rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .req(bus.req),
    .ptr(rr_ptr),
    .sel(sel_oh),
    .idx(sel_idx),
    .any(sel_any)
  );
  assign expired = to_ctr == TO_CTR_SIZE'(TIMEOUT);
  always_comb begin
    state_d = state;
    grant_d = grant_q;
    done_d = done_q;
    err_d = err_q;
    start_d = start_q;
    grst_d = grst_q;
    rr_d = rr_ptr;
    to_d = to_ctr;
    case (state)
      IDLE: if (bus.gen_done && sel_any) begin
        grant_d = sel_oh;
        start_d = 1'b1;
        rr_d = sel_idx;
        to_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        start_d = 1'b0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (state == WAIT_BUSY && !bus.gen_done) begin
          to_d = '0;
          state_d = WAIT_DONE;
        end else if (state == WAIT_DONE && bus.gen_done) begin
          done_d = grant_q;
          grant_d = '0;
          state_d = RELEASE;
        end else if (expired) begin
          done_d = grant_q;
          err_d = 1'b1;
          grst_d = 1'b1;
          grant_d = '0;
          state_d = RELEASE;
        end else begin
          to_d = to_ctr + 1'b1;
        end
      end
      RELEASE: begin
        done_d = '0;
        err_d = 1'b0;
        grst_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      grst_q <= 1'b0;
      rr_ptr <= IDX_W'(NUM_REQ - 1);
      to_ctr <= '0;
    end else begin
      state <= state_d;
      grant_q <= grant_d;
      done_q <= done_d;
      err_q <= err_d;
      start_q <= start_d;
      grst_q <= grst_d;
      rr_ptr <= rr_d;
      to_ctr <= to_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.gen_start = start_q;
  assign bus.gen_rst = grst_q;
endmodule

// File: doc/pulse_gen_arbiter.md
Name: pulse_gen_arbiter

Overview:
Round-robin arbiter sharing one pulse generator instance (SCLK/strobe source) between NUM_REQ requesters, e.g. the MITM bus-side and host-side interface FSMs.
- Grants one requester at a time.
- Issues a single-cycle start to the generator.
- Tracks the generator's done handshake (done high when idle, low while busy).
- Returns a per-requester completion pulse.
- A watchdog recovers the generator if its handshake stalls.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 1023, max cycles in WAIT_BUSY or WAIT_DONE before abort (>= CYCLE_COUNT*CYCLE_LEN+4 of the shared generator)
TO_CTR_SIZE, $clog2(TIMEOUT+1), watchdog counter width (derived localparam, not overridable)

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request per requester; hold until own done/err pulse
grant  out  NUM_REQ  one-hot (or zero); high from ISSUE through last cycle of WAIT_DONE
done  out  NUM_REQ  one-cycle completion pulse to granted requester
err  out  1  one-cycle pulse coincident with done when transaction aborted by timeout
gen_start  out  1  one-cycle start to generator
gen_done  in  1  generator done/idle flag
gen_rst  out  1  one-cycle synchronous reset to generator on timeout

Behaviour:
- All outputs registered. Reset values: grant=0, done=0, err=0, gen_start=0, gen_rst=0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), to_ctr=0.
- rst mid-transaction: outputs drop to reset values on the next edge, no done pulse, generator not touched (it has its own rst).
- States:
  - IDLE: if gen_done==1 and |req → pick the first set req bit scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ; grant<=onehot(sel), gen_start<=1, rr_ptr<=sel, to_ctr<=0 → ISSUE. If gen_done==0 (generator still in its own reset), stay in IDLE; no grant.
  - ISSUE (1 cycle): gen_start<=0 → WAIT_BUSY.
  - WAIT_BUSY: gen_done==0 → WAIT_DONE, to_ctr<=0. Otherwise to_ctr++.
  - WAIT_DONE: gen_done==1 → done<=grant, grant<=0 → RELEASE. Otherwise to_ctr++.
  - RELEASE (1 cycle): done<=0, err<=0, gen_rst<=0 → IDLE.
  - Timeout: in WAIT_BUSY or WAIT_DONE, if to_ctr==TIMEOUT → done<=grant, err<=1, gen_rst<=1, grant<=0 → RELEASE.
- Latency:
  - req (with IDLE and gen_done=1) to grant/gen_start: 1 cycle.
  - gen_start pulse width: exactly 1 cycle.
  - Generator done rising to done pulse: 1 cycle.
  - Minimum gap between consecutive grants: 2 cycles (RELEASE, IDLE).
- Requests:
  - Sampled only in IDLE. Requests arriving mid-transaction wait; no loss.
  - req deassert while granted is ignored: the transaction completes and done still pulses.
  - Simultaneous requests are resolved by round robin only. With all req high, grants rotate 0,1,…,NUM_REQ-1,0. rr_ptr wraps NUM_REQ-1 → 0.
- After a timeout, IDLE waits for gen_done==1 (generator re-runs its reset state) before the next grant.
- Invariants:
  - grant is never multi-hot.
  - gen_start is never high outside the ISSUE entry edge.
  - err is never high without done.

Decomposition:
- Shared package: state encodings (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/RELEASE, 3 bits) and the NUM_REQ upper limit.
- One sub-module, rr_select: combinational first-set search from rr_ptr+1 with wrap, output one-hot plus index.
- Watchdog counter stays inline.

Test Plan:
1. Reset, gen_done=1, req=2'b01 → grant=01 and gen_start=1 one cycle after req. Bench generator drops gen_done next cycle, raises it 50 cycles later → done=01 pulse 1 cycle after gen_done rises, err=0.
2. NUM_REQ=3, req=3'b111 held for 6 transactions → grant order 001,010,100,001,010,100; each grant is separated by ≥2 idle cycles.
3. Generator never drops gen_done, TIMEOUT=15 → done pulse, err=1, gen_rst=1, all in the same cycle, 16 cycles after WAIT_BUSY entry; grant=0 afterwards.
4. gen_done held low after reset for 5 cycles, with req=01 → no grant until gen_done=1, then normal grant.
5. rst asserted in WAIT_DONE → next edge grant=0, done=0, gen_start=0; a fresh req=10 after reset is granted first only if req[0]=0. With req=11, requester 0 is granted first.
6. Requester drops req one cycle after grant → transaction completes; done pulse still delivered to that index.
